// File: rtl/instr_mem_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader_if
// Description : Host byte stream, instruction memory write port and processor
//               status signals of the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
   parameter int ADDR_WIDTH = 5
);
   logic                  Start;
   logic [7:0]            In_Data;
   logic                  In_Valid;
   logic                  In_Ready;
   logic                  Mem_We;
   logic [ADDR_WIDTH-1:0] Mem_Addr;
   logic [31:0]           Mem_Wdata;
   logic                  Cpu_Hold;
   logic                  Done;
   logic                  Error;
   logic [ADDR_WIDTH:0]   Words_Loaded;

   // Host / bench side: drives the stream, observes the loader
   modport master (
      output Start, In_Data, In_Valid,
      input  In_Ready, Mem_We, Mem_Addr, Mem_Wdata, Cpu_Hold, Done, Error, Words_Loaded
   );

   // Loader side
   modport slave (
      input  Start, In_Data, In_Valid,
      output In_Ready, Mem_We, Mem_Addr, Mem_Wdata, Cpu_Hold, Done, Error, Words_Loaded
   );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Receives a length byte plus little-endian instruction bytes,
//               writes one 32-bit word per instruction into instruction memory
//               and holds the processor in reset until loading completes.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Reset,
   instr_mem_loader_if.slave  bus
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [7:0]            len_q;
   logic [1:0]            idx_q;
   logic [DATA_WIDTH-1:0] word_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH:0]   words_q;

   logic in_ready, mem_we, cpu_hold, done, error;
   logic xfer, len_over, last_word;

   assign xfer      = bus.In_Valid & in_ready;
   // Length byte larger than the memory depth is rejected (N == DEPTH is legal)
   assign len_over  = {24'd0, bus.In_Data} > 32'(DEPTH);
   // Compared against the count as it will be after this write
   assign last_word = (32'(words_q) + 32'd1) == {24'd0, len_q};

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode; Start only matters in IDLE, DONE and ERR
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.Start) state_d = S_LEN;
         S_LEN: begin
            if (xfer) begin
               if (bus.In_Data == 8'd0) state_d = S_DONE;
               else if (len_over)       state_d = S_ERR;
               else                     state_d = S_DATA;
            end
         end
         S_DATA:  if (xfer && idx_q == 2'd3) state_d = S_WRITE;
         S_WRITE: state_d = last_word ? S_DONE : S_DATA;
         S_DONE:  if (bus.Start) state_d = S_LEN;
         S_ERR:   if (bus.Start) state_d = S_LEN;
         default: state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs; the processor runs only after a clean load
   always_comb begin
      in_ready = (state_q == S_LEN) || (state_q == S_DATA);
      mem_we   = (state_q == S_WRITE);
      cpu_hold = (state_q != S_DONE);
      done     = (state_q == S_DONE);
      error    = (state_q == S_ERR);
   end

   // Datapath: length capture, byte assembly, write address/data, word count
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         len_q   <= 8'd0;
         idx_q   <= 2'd0;
         word_q  <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         words_q <= '0;
      end else begin
         // A new length starts a fresh session count, whatever its outcome
         if (state_q == S_LEN && xfer) begin
            len_q   <= bus.In_Data;
            idx_q   <= 2'd0;
            words_q <= '0;
         end
         if (state_q == S_DATA && xfer) begin
            word_q[{idx_q, 3'b000} +: 8] <= bus.In_Data;
            idx_q                        <= idx_q + 2'd1;
            // Capture the completed word so it is stable through WRITE and held after
            if (idx_q == 2'd3) begin
               wdata_q <= {bus.In_Data, word_q[DATA_WIDTH-9:0]};
               addr_q  <= words_q[ADDR_WIDTH-1:0];
            end
         end
         if (state_q == S_WRITE) begin
            words_q <= words_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
         end
      end
   end

   assign bus.In_Ready     = in_ready;
   assign bus.Mem_We       = mem_we;
   assign bus.Mem_Addr     = addr_q;
   assign bus.Mem_Wdata    = wdata_q;
   assign bus.Cpu_Hold     = cpu_hold;
   assign bus.Done         = done;
   assign bus.Error        = error;
   assign bus.Words_Loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Directed self-checking bench for instr_mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

   logic Clk;
   logic Reset;
   int   n_total;
   int   n_pass;
   int   wr_cnt;
   int   w0;

   instr_mem_loader_if #(.ADDR_WIDTH(5)) bus ();

   instr_mem_loader #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Count write pulses mid-cycle
   always @(negedge Clk) begin
      if (bus.Mem_We === 1'b1) wr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start();
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
   endtask

   // Present a byte and hold it until it transfers; In_Valid stays high afterwards
   task automatic send(input logic [7:0] b);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      bus.In_Data  = b;
      bus.In_Valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         rdy = bus.In_Ready;
         tick();
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("xfer_timeout", 32'(ok), 32'd1);
   endtask

   task automatic check_reset_state(input string p);
      check({p, "_ready"}, bus.In_Ready,     0);
      check({p, "_we"},    bus.Mem_We,       0);
      check({p, "_addr"},  bus.Mem_Addr,     0);
      check({p, "_wdata"}, bus.Mem_Wdata,    0);
      check({p, "_hold"},  bus.Cpu_Hold,     1);
      check({p, "_done"},  bus.Done,         0);
      check({p, "_err"},   bus.Error,        0);
      check({p, "_wl"},    bus.Words_Loaded, 0);
   endtask

   initial begin
      logic [7:0] gb [4];
      n_total = 0;
      n_pass  = 0;
      wr_cnt  = 0;
      Reset        = 1'b1;
      bus.Start    = 1'b0;
      bus.In_Valid = 1'b0;
      bus.In_Data  = 8'd0;
      gb[0] = 8'hEF; gb[1] = 8'hBE; gb[2] = 8'hAD; gb[3] = 8'hDE;

      // ---------------- reset state ----------------
      #12;
      check_reset_state("rst");
      @(posedge Clk); #3;
      Reset = 1'b0;
      tick();
      check("idle_ready", bus.In_Ready, 0);

      // ---------------- two-word load, valid held high ----------------
      start();
      check("t1_len_ready", bus.In_Ready, 1);
      send(8'h02);
      send(8'h13); send(8'h00); send(8'h20); send(8'h00);
      check("t1_w0_we",    bus.Mem_We,    1);
      check("t1_w0_addr",  bus.Mem_Addr,  0);
      check("t1_w0_data",  bus.Mem_Wdata, 32'h0020_0013);
      check("t1_w0_ready", bus.In_Ready,  0);
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      check("t1_w1_we",    bus.Mem_We,    1);
      check("t1_w1_addr",  bus.Mem_Addr,  1);
      check("t1_w1_data",  bus.Mem_Wdata, 32'hDDCC_BBAA);
      tick();
      bus.In_Valid = 1'b0;
      check("t1_done",     bus.Done,         1);
      check("t1_hold",     bus.Cpu_Hold,     0);
      check("t1_wl",       bus.Words_Loaded, 2);
      check("t1_we_low",   bus.Mem_We,       0);
      check("t1_addr_hld", bus.Mem_Addr,     1);
      check("t1_data_hld", bus.Mem_Wdata,    32'hDDCC_BBAA);
      check("t1_wr_cnt",   wr_cnt,           2);

      // ---------------- zero length ----------------
      start();
      check("t2_done_clr", bus.Done,     0);
      check("t2_hold_set", bus.Cpu_Hold, 1);
      w0 = wr_cnt;
      send(8'h00);
      bus.In_Valid = 1'b0;
      check("t2_done",  bus.Done,         1);
      check("t2_hold",  bus.Cpu_Hold,     0);
      check("t2_wl",    bus.Words_Loaded, 0);
      check("t2_ready", bus.In_Ready,     0);
      tick(); tick();
      check("t2_no_wr", wr_cnt, w0);

      // ---------------- oversize length ----------------
      start();
      send(8'h21);
      check("t3_err",   bus.Error,    1);
      check("t3_hold",  bus.Cpu_Hold, 1);
      check("t3_ready", bus.In_Ready, 0);
      check("t3_done",  bus.Done,     0);
      tick(); tick(); tick();
      check("t3_err_stk", bus.Error, 1);
      check("t3_no_wr",   wr_cnt,    w0);
      bus.In_Valid = 1'b0;
      start();
      check("t3_err_clr",  bus.Error,    0);
      check("t3_ready_bk", bus.In_Ready, 1);

      // ---------------- one word with 3-cycle gaps ----------------
      send(8'h01);
      bus.In_Valid = 1'b0;
      bus.In_Data  = 8'hFF;
      for (int g = 0; g < 3; g++) begin
         tick();
         check("t4_gap_ready", bus.In_Ready, 1);
      end
      for (int j = 0; j < 4; j++) begin
         send(gb[j]);
         bus.In_Valid = 1'b0;
         bus.In_Data  = 8'hFF;
         if (j < 3) begin
            for (int g = 0; g < 3; g++) begin
               tick();
               check("t4_gap_ready", bus.In_Ready, 1);
               check("t4_gap_we",    bus.Mem_We,   0);
            end
         end
      end
      check("t4_we",    bus.Mem_We,    1);
      check("t4_addr",  bus.Mem_Addr,  0);
      check("t4_data",  bus.Mem_Wdata, 32'hDEAD_BEEF);
      check("t4_ready", bus.In_Ready,  0);
      tick();
      check("t4_done",   bus.Done,         1);
      check("t4_wl",     bus.Words_Loaded, 1);
      check("t4_wr_cnt", wr_cnt,           w0 + 1);

      // ---------------- async reset mid-load ----------------
      start();
      send(8'h04);
      send(8'h11); send(8'h22);
      bus.In_Valid = 1'b0;
      #3 Reset = 1'b1;
      #1;
      check_reset_state("t5_async");
      @(posedge Clk); #3;
      Reset = 1'b0;
      tick();
      check("t5_idle_ready", bus.In_Ready, 0);
      start();
      send(8'h02);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      check("t5_w0_we",   bus.Mem_We,    1);
      check("t5_w0_addr", bus.Mem_Addr,  0);
      check("t5_w0_data", bus.Mem_Wdata, 32'h0403_0201);
      send(8'h05); send(8'h06); send(8'h07); send(8'h08);
      check("t5_w1_addr", bus.Mem_Addr,  1);
      check("t5_w1_data", bus.Mem_Wdata, 32'h0807_0605);
      tick();
      bus.In_Valid = 1'b0;
      check("t5_done", bus.Done,         1);
      check("t5_wl",   bus.Words_Loaded, 2);

      // ---------------- full depth, Start pulses ignored mid-load ----------------
      start();
      w0 = wr_cnt;
      send(8'h20);
      for (int i = 0; i < 32; i++) begin
         if (i == 5) bus.Start = 1'b1;
         send(8'(i)); send(8'(i + 1)); send(8'hA5); send(8'h3C);
         check("t6_we",   bus.Mem_We,    1);
         check("t6_addr", bus.Mem_Addr,  32'(i));
         check("t6_data", bus.Mem_Wdata, {8'h3C, 8'hA5, 8'(i + 1), 8'(i)});
         bus.Start = 1'b0;
      end
      tick();
      bus.In_Valid = 1'b0;
      check("t6_done",   bus.Done,         1);
      check("t6_hold",   bus.Cpu_Hold,     0);
      check("t6_wl",     bus.Words_Loaded, 32);
      check("t6_wr_cnt", wr_cnt,           w0 + 32);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
